// File: rtl/cam_access_controller_if.sv
// cam_access_controller_if: the bundle of wires between the CAM access controller,
// its clients and the CAM itself.
//   Insert port : ins_req, ins_key -> ins_done, ins_addr, ins_new
//   Lookup port : lk_req, lk_key   -> lk_done, lk_hit, lk_addr
//   CAM pins    : cam_wen, cam_ren, cam_din, cam_addr -> CAM; cam_dout, cam_hit <- CAM
//   Status      : count, full
// modport slave is the controller; modport master is the client/CAM side.
interface cam_access_controller_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              ins_req;
  logic [DATA_W-1:0] ins_key;
  logic              ins_done;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_new;
  logic              lk_req;
  logic [DATA_W-1:0] lk_key;
  logic              lk_done;
  logic              lk_hit;
  logic [ADDR_W-1:0] lk_addr;
  logic              cam_wen;
  logic              cam_ren;
  logic [DATA_W-1:0] cam_din;
  logic [ADDR_W-1:0] cam_addr;
  logic [ADDR_W-1:0] cam_dout;
  logic              cam_hit;
  logic [ADDR_W:0]   count;
  logic              full;

  modport slave (
    input  ins_req, ins_key, lk_req, lk_key, cam_dout, cam_hit,
    output ins_done, ins_addr, ins_new, lk_done, lk_hit, lk_addr,
    output cam_wen, cam_ren, cam_din, cam_addr, count, full
  );

  modport master (
    output ins_req, ins_key, lk_req, lk_key, cam_dout, cam_hit,
    input  ins_done, ins_addr, ins_new, lk_done, lk_hit, lk_addr,
    input  cam_wen, cam_ren, cam_din, cam_addr, count, full
  );
endinterface

// File: rtl/cam_access_controller.sv
// cam_access_controller: round-robin sequencer between an insert port and a
// lookup port in front of a 16x8 CAM. Inserts search first and only write on a
// miss; write addresses are handed out in FIFO order (oldest overwritten when
// full). A valid bitmap masks CAM hits on entries never written since reset.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - cam_access_controller_if.slave (client ports, CAM pins, count/full)
module cam_access_controller #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int ENTRIES = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  cam_access_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(ENTRIES);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t              state_r;
  logic                op_ins_r;       // 1 = current op is an insert
  logic                last_ins_r;     // 1 = insert port granted last
  logic [DATA_W-1:0]   key_r;
  logic [ENTRIES-1:0]  valid_r;
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W:0]     count_r;
  logic                full_r;
  logic                ins_done_r;
  logic [ADDR_W-1:0]   ins_addr_r;
  logic                ins_new_r;
  logic                lk_done_r;
  logic                lk_hit_r;
  logic [ADDR_W-1:0]   lk_addr_r;
  logic                cam_wen_r;
  logic                cam_ren_r;
  logic [DATA_W-1:0]   cam_din_r;
  logic [ADDR_W-1:0]   cam_addr_r;

  logic                hit_eff_s;
  logic                grant_ins_s;
  logic [ADDR_W:0]     count_inc_s;

  // CAM hit qualified by the valid bitmap so stale contents never match.
  always_comb begin
    hit_eff_s = bus.cam_hit & valid_r[bus.cam_dout];
  end

  // Round-robin pick: on a tie the port not served last wins.
  always_comb begin
    if (bus.ins_req && bus.lk_req) begin
      grant_ins_s = ~last_ins_r;
    end else begin
      grant_ins_s = bus.ins_req;
    end
  end

  // Saturating entry count after a write (overwrites keep it at full).
  always_comb begin
    if (count_r == FULL_CNT) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + CNT_ONE;
    end
  end

  // Main sequencer: state, bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      op_ins_r   <= 1'b0;
      last_ins_r <= 1'b0;
      key_r      <= '0;
      valid_r    <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      ins_done_r <= 1'b0;
      ins_addr_r <= '0;
      ins_new_r  <= 1'b0;
      lk_done_r  <= 1'b0;
      lk_hit_r   <= 1'b0;
      lk_addr_r  <= '0;
      cam_wen_r  <= 1'b0;
      cam_ren_r  <= 1'b0;
      cam_din_r  <= '0;
      cam_addr_r <= '0;
    end else begin
      // Pulses and enables are single-cycle unless re-asserted below.
      ins_done_r <= 1'b0;
      lk_done_r  <= 1'b0;
      cam_wen_r  <= 1'b0;
      cam_ren_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.ins_req || bus.lk_req) begin
            op_ins_r   <= grant_ins_s;
            last_ins_r <= grant_ins_s;
            key_r      <= grant_ins_s ? bus.ins_key : bus.lk_key;
            // Search is issued in the cycle after the grant.
            cam_ren_r  <= 1'b1;
            cam_din_r  <= grant_ins_s ? bus.ins_key : bus.lk_key;
            state_r    <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          state_r <= CHECK;
        end
        CHECK: begin
          if (!op_ins_r) begin
            lk_hit_r  <= hit_eff_s;
            lk_addr_r <= hit_eff_s ? bus.cam_dout : '0;
            lk_done_r <= 1'b1;
            state_r   <= RESP;
          end else if (hit_eff_s) begin
            ins_addr_r <= bus.cam_dout;
            ins_new_r  <= 1'b0;
            ins_done_r <= 1'b1;
            state_r    <= RESP;
          end else begin
            cam_wen_r  <= 1'b1;
            cam_addr_r <= wr_ptr_r;
            cam_din_r  <= key_r;
            state_r    <= WRITE;
          end
        end
        WRITE: begin
          valid_r[wr_ptr_r] <= 1'b1;
          ins_addr_r        <= wr_ptr_r;
          ins_new_r         <= 1'b1;
          ins_done_r        <= 1'b1;
          wr_ptr_r          <= wr_ptr_r + PTR_ONE;
          count_r           <= count_inc_s;
          full_r            <= (count_inc_s == FULL_CNT);
          state_r           <= RESP;
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ins_done = ins_done_r;
  assign bus.ins_addr = ins_addr_r;
  assign bus.ins_new  = ins_new_r;
  assign bus.lk_done  = lk_done_r;
  assign bus.lk_hit   = lk_hit_r;
  assign bus.lk_addr  = lk_addr_r;
  assign bus.cam_wen  = cam_wen_r;
  assign bus.cam_ren  = cam_ren_r;
  assign bus.cam_din  = cam_din_r;
  assign bus.cam_addr = cam_addr_r;
  assign bus.count    = count_r;
  assign bus.full     = full_r;

endmodule

// File: tb/tb_cam_access_controller.sv
// tb_cam_access_controller: directed bench for cam_access_controller with a
// behavioural 16x8 CAM (1-cycle search latency, lowest index wins).
module tb_cam_access_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cam_access_controller_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  cam_access_controller #(.DATA_W(8), .ADDR_W(4), .ENTRIES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM: contents survive controller reset.
  logic [7:0] cam_mem [16];

  function automatic logic [4:0] cam_search(input logic [7:0] k);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (cam_mem[i] == k) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) cam_mem[i] = 8'hFF;
  end

  always @(posedge clk) begin
    if (bus.cam_wen) cam_mem[bus.cam_addr] <= bus.cam_din;
    if (bus.cam_ren) {bus.cam_hit, bus.cam_dout} <= cam_search(bus.cam_din);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ins_req = 1'b0;
    bus.lk_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction on one port; latency counted in cycles after the grant edge.
  task automatic do_op(input bit is_ins, input logic [7:0] key,
                       output bit got, output int lat, output bit flag,
                       output logic [3:0] addr, output int nwen, output int nren,
                       output logic [7:0] wdin, output logic [3:0] waddr);
    got = 1'b0; lat = 0; flag = 1'b0; addr = 4'd0; nwen = 0; nren = 0;
    wdin = 8'd0; waddr = 4'd0;
    @(negedge clk);
    if (is_ins) begin
      bus.ins_key = key; bus.ins_req = 1'b1;
    end else begin
      bus.lk_key = key; bus.lk_req = 1'b1;
    end
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (bus.cam_wen) begin
        nwen++; wdin = bus.cam_din; waddr = bus.cam_addr;
      end
      if (bus.cam_ren) nren++;
      if (is_ins && bus.ins_done) begin
        got = 1'b1; lat = c; flag = bus.ins_new; addr = bus.ins_addr;
      end else if (!is_ins && bus.lk_done) begin
        got = 1'b1; lat = c; flag = bus.lk_hit; addr = bus.lk_addr;
      end
    end
    bus.ins_req = 1'b0;
    bus.lk_req  = 1'b0;
  endtask

  // Simultaneous requests on both ports; reports which finished first.
  task automatic run_pair(input logic [7:0] ik, input logic [7:0] lkk,
                          output bit ok, output bit first_ins,
                          output bit inew, output logic [3:0] iaddr,
                          output bit lhit, output logic [3:0] laddr);
    bit gi, gl;
    gi = 1'b0; gl = 1'b0; first_ins = 1'b0;
    inew = 1'b0; iaddr = 4'd0; lhit = 1'b0; laddr = 4'd0;
    @(negedge clk);
    bus.ins_key = ik;  bus.ins_req = 1'b1;
    bus.lk_key  = lkk; bus.lk_req  = 1'b1;
    for (int c = 0; c < 30 && !(gi && gl); c++) begin
      @(negedge clk);
      if (bus.ins_done && !gi) begin
        gi = 1'b1; first_ins = !gl; inew = bus.ins_new; iaddr = bus.ins_addr;
        bus.ins_req = 1'b0;
      end
      if (bus.lk_done && !gl) begin
        gl = 1'b1; lhit = bus.lk_hit; laddr = bus.lk_addr;
        bus.lk_req = 1'b0;
      end
    end
    bus.ins_req = 1'b0;
    bus.lk_req  = 1'b0;
    ok = gi && gl;
  endtask

  typedef struct {
    bit         rst;
    bit         ins;
    logic [7:0] key;
    bit         exp_flag;   // ins_new for inserts, lk_hit for lookups
    logic [3:0] exp_addr;
    logic [4:0] exp_cnt;
    bit         exp_full;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit ins, input logic [7:0] k,
                              input bit f, input logic [3:0] a,
                              input logic [4:0] c, input bit fl);
    vec_t v;
    v.rst = r; v.ins = ins; v.key = k; v.exp_flag = f;
    v.exp_addr = a; v.exp_cnt = c; v.exp_full = fl;
    vecs.push_back(v);
  endfunction

  initial begin
    bit         got, flag, ok, fi, inew, lhit;
    int         lat, nwen, nren, exp_lat;
    logic [3:0] addr, waddr, iaddr, laddr;
    logic [7:0] wdin;
    int         wen_seen;
    int         done_seen;

    total = 0; bad = 0;
    rst_n = 1'b1;
    bus.ins_req = 1'b0; bus.ins_key = 8'd0;
    bus.lk_req  = 1'b0; bus.lk_key  = 8'd0;

    // Vector table: fresh lookup, FIFO inserts, dedup, masking after reset, wrap.
    add(1'b1, 1'b0, 8'd4,   1'b0, 4'd0, 5'd0,  1'b0);
    add(1'b0, 1'b1, 8'd4,   1'b1, 4'd0, 5'd1,  1'b0);
    add(1'b0, 1'b1, 8'd8,   1'b1, 4'd1, 5'd2,  1'b0);
    add(1'b0, 1'b1, 8'd35,  1'b1, 4'd2, 5'd3,  1'b0);
    add(1'b0, 1'b0, 8'd8,   1'b1, 4'd1, 5'd3,  1'b0);
    add(1'b0, 1'b0, 8'd87,  1'b0, 4'd0, 5'd3,  1'b0);
    add(1'b0, 1'b1, 8'd8,   1'b0, 4'd1, 5'd3,  1'b0);
    add(1'b1, 1'b0, 8'd4,   1'b0, 4'd0, 5'd0,  1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b1, 8'(100 + i), 1'b1, 4'(i), 5'(i + 1), (i == 15));
    add(1'b0, 1'b1, 8'd200, 1'b1, 4'd0,  5'd16, 1'b1);
    add(1'b0, 1'b0, 8'd100, 1'b0, 4'd0,  5'd16, 1'b1);
    add(1'b0, 1'b0, 8'd200, 1'b1, 4'd0,  5'd16, 1'b1);
    add(1'b0, 1'b0, 8'd115, 1'b1, 4'd15, 5'd16, 1'b1);
    add(1'b0, 1'b1, 8'd101, 1'b0, 4'd1,  5'd16, 1'b1);
    add(1'b0, 1'b1, 8'd201, 1'b1, 4'd1,  5'd16, 1'b1);
    add(1'b0, 1'b0, 8'd101, 1'b0, 4'd0,  5'd16, 1'b1);

    // Reset values.
    do_reset();
    @(negedge clk);
    chk("rst_ins_done", {31'd0, bus.ins_done}, 32'd0);
    chk("rst_lk_done",  {31'd0, bus.lk_done},  32'd0);
    chk("rst_cam_wen",  {31'd0, bus.cam_wen},  32'd0);
    chk("rst_cam_ren",  {31'd0, bus.cam_ren},  32'd0);
    chk("rst_count",    {27'd0, bus.count},    32'd0);
    chk("rst_full",     {31'd0, bus.full},     32'd0);
    chk("rst_results",  {22'd0, bus.lk_hit, bus.lk_addr, bus.ins_new, bus.ins_addr}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      do_op(vecs[i].ins, vecs[i].key, got, lat, flag, addr, nwen, nren, wdin, waddr);
      exp_lat = (vecs[i].ins && vecs[i].exp_flag) ? 4 : 3;
      chk($sformatf("v%0d_done", i), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_lat", i), lat, exp_lat);
      chk($sformatf("v%0d_flag", i), {31'd0, flag}, {31'd0, vecs[i].exp_flag});
      chk($sformatf("v%0d_addr", i), {28'd0, addr}, {28'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_count", i), {27'd0, bus.count}, {27'd0, vecs[i].exp_cnt});
      chk($sformatf("v%0d_full", i), {31'd0, bus.full}, {31'd0, vecs[i].exp_full});
      chk($sformatf("v%0d_nren", i), nren, 1);
      chk($sformatf("v%0d_nwen", i), nwen, (vecs[i].ins && vecs[i].exp_flag) ? 1 : 0);
      if (vecs[i].ins && vecs[i].exp_flag) begin
        chk($sformatf("v%0d_wdin", i), {24'd0, wdin}, {24'd0, vecs[i].key});
        chk($sformatf("v%0d_waddr", i), {28'd0, waddr}, {28'd0, vecs[i].exp_addr});
      end
    end

    // Arbitration: first tie after reset goes to insert.
    do_reset();
    run_pair(8'd45, 8'd35, ok, fi, inew, iaddr, lhit, laddr);
    chk("pair1_done", {31'd0, ok}, 32'd1);
    chk("pair1_ins_first", {31'd0, fi}, 32'd1);
    chk("pair1_ins", {27'd0, inew, iaddr}, {27'd0, 1'b1, 4'd0});
    chk("pair1_lk", {27'd0, lhit, laddr}, 32'd0);
    // Lone insert makes insert the last grant, so the next tie goes to lookup.
    do_op(1'b1, 8'd50, got, lat, flag, addr, nwen, nren, wdin, waddr);
    chk("solo_ins", {26'd0, got, flag, addr}, {26'd0, 1'b1, 1'b1, 4'd1});
    run_pair(8'd77, 8'd45, ok, fi, inew, iaddr, lhit, laddr);
    chk("pair2_done", {31'd0, ok}, 32'd1);
    chk("pair2_ins_first", {31'd0, fi}, 32'd0);
    chk("pair2_ins", {27'd0, inew, iaddr}, {27'd0, 1'b1, 4'd2});
    chk("pair2_lk", {27'd0, lhit, laddr}, {27'd0, 1'b1, 4'd0});
    chk("pair2_count", {27'd0, bus.count}, 32'd3);

    // Reset in the middle of a write.
    do_reset();
    @(negedge clk);
    bus.ins_key = 8'd60; bus.ins_req = 1'b1;
    wen_seen = 0;
    for (int c = 0; c < 10 && wen_seen == 0; c++) begin
      @(negedge clk);
      if (bus.cam_wen) wen_seen = 1;
    end
    chk("mid_wen_seen", wen_seen, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_wen_drop", {31'd0, bus.cam_wen}, 32'd0);
    chk("mid_count", {27'd0, bus.count}, 32'd0);
    bus.ins_req = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.ins_done) done_seen = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.ins_done) done_seen = 1;
    end
    chk("mid_no_done", done_seen, 0);
    do_op(1'b0, 8'd60, got, lat, flag, addr, nwen, nren, wdin, waddr);
    chk("mid_lk_done", {31'd0, got}, 32'd1);
    chk("mid_lk_hit", {31'd0, flag}, 32'd0);
    chk("mid_lk_addr", {28'd0, addr}, 32'd0);
    chk("mid_lk_count", {27'd0, bus.count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_access_controller.md
# cam_access_controller

Sequencer and arbiter for the 16-entry × 8-bit content addressable memory. It serves two requesters, an insert port and a lookup port, with round-robin arbitration, and drives the CAM's `wen`/`ren`/`din`/`addr` pins. It allocates write addresses automatically in FIFO order, deduplicates inserts with a lookup-before-write, and masks hits on never-written entries with a valid bitmap. It sits between the client logic and the CAM, which is the only agent allowed to touch the CAM ports.

## Interface
Parameters:
- `DATA_W`, 8: key width; equals the CAM `din` width.
- `ADDR_W`, 4: CAM address width.
- `ENTRIES`, 16: CAM depth; equals 2^`ADDR_W`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ins_req`  in  1  insert request, level; held with `ins_key` until `ins_done`.
- `ins_key`  in  DATA_W  key to insert.
- `ins_done`  out  1  one-cycle pulse; the insert has completed.
- `ins_addr`  out  ADDR_W  entry holding the key; valid while `ins_done`=1.
- `ins_new`  out  1  1 = key written now; 0 = key already present.
- `lk_req`  in  1  lookup request, level; held with `lk_key` until `lk_done`.
- `lk_key`  in  DATA_W  key to search.
- `lk_done`  out  1  one-cycle pulse; the lookup has completed.
- `lk_hit`  out  1  key found in a valid entry.
- `lk_addr`  out  ADDR_W  matching entry; 0 when `lk_hit`=0.
- `cam_wen`, `cam_ren`  out  1  CAM write and search enables.
- `cam_din`  out  DATA_W  CAM key or write data.
- `cam_addr`  out  ADDR_W  CAM write address.
- `cam_dout`  in  ADDR_W  CAM match address.
- `cam_hit`  in  1  CAM match flag.
- `count`  out  ADDR_W+1  number of valid entries, 0..16.
- `full`  out  1  `count`==16.

## Operation
- State: `valid[15:0]`, `wr_ptr[3:0]`, `count`, `last_grant`, latched `op` and `key`.
- FSM states: IDLE, ISSUE, CHECK, WRITE, RESP.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not granted last.
  - On grant: latch `op` and `key`, update `last_grant`, go to ISSUE.
  - Reset value of `last_grant` = lookup, so insert wins the first tie.
- **ISSUE:** `cam_ren`=1, `cam_din`=`key`. Go to CHECK.
- **CHECK:**
  - CAM result is valid in this state (1-cycle CAM search latency).
  - `hit_eff` = `cam_hit` & `valid[cam_dout]`.
  - Lookup: go to RESP with `lk_hit`=`hit_eff`, `lk_addr`=`hit_eff ? cam_dout : 0`.
  - Insert with `hit_eff`=1: go to RESP with `ins_addr`=`cam_dout`, `ins_new`=0.
  - Insert with `hit_eff`=0: go to WRITE.
- **WRITE:**
  - `cam_wen`=1, `cam_addr`=`wr_ptr`, `cam_din`=`key`.
  - At the edge: `valid[wr_ptr]`←1, result `ins_addr`=`wr_ptr` and `ins_new`=1.
  - `wr_ptr`←`wr_ptr`+1, wrapping 15→0.
  - `count` increments, saturating at 16.
  - Go to RESP.
- **RESP:** pulse the matching `*_done` for one cycle, hold result outputs, go to IDLE.
- **Full:** when `count`=16, inserts overwrite the oldest entry (`wr_ptr`). `count` stays 16. The overwritten key no longer matches.
- **Uniqueness:** keys are unique across valid entries by construction, so CAM priority order is irrelevant.
- **Drive rules:**
  - `cam_*` outputs come from state and latched registers only; no combinational path from `*_req`/`*_key`.
  - In IDLE, CHECK and RESP: `cam_wen`=`cam_ren`=0.
  - `cam_din` and `cam_addr` hold their last values outside ISSUE and WRITE.
- **Reset values:** all outputs 0, `valid`=0, `wr_ptr`=0, `count`=0, state IDLE.
- **Reset mid-operation:** the operation is aborted with no `done`, and `cam_wen` drops immediately. CAM contents are retained but ignored because `valid` is cleared.

## Timing
- Lookup: grant edge (end of IDLE) → `lk_done` high 3 cycles later (ISSUE, CHECK, RESP).
- Insert that hits: 3 cycles. Insert that misses: 4 cycles. Exactly one `cam_wen` cycle per miss.
- Handshake: the requester deasserts or changes `req` at the edge that ends the RESP cycle. A `req` still high in the following IDLE is a new request.
- Throughput:
  - One operation in flight; at least 1 IDLE cycle between operations.
  - Back-to-back lookups complete every 4 cycles; back-to-back insert misses every 5.
- A request arriving while the FSM is busy waits, unacknowledged, in `req`.

## Test plan
1. Reset, then lookup 4 → `lk_done` 3 cycles after grant, `lk_hit`=0, `lk_addr`=0, `cam_wen` never high.
2. Insert 4, 8, 35 → `ins_addr`=0, 1, 2 with `ins_new`=1 and `count`=3. Then lookup 8 → hit at addr 1; lookup 87 → miss.
3. After scenario 2, insert 8 again → `ins_new`=0, `ins_addr`=1, no `cam_wen` pulse, `count` stays 3.
4. Assert `ins_req`(45) and `lk_req`(35) together from reset → insert served first, lookup second. A second simultaneous pair → lookup served first.
5. Insert keys 100..115 → `full`=1, `count`=16. Insert 200 → `ins_addr`=0, `ins_new`=1. Lookup 100 → miss; lookup 200 → hit at 0; lookup 115 → hit at 15.
6. Drop `rst_n` low during WRITE of key 60 → `cam_wen` goes 0 at once, no `ins_done`, `count`=0. After release, lookup 60 → `lk_hit`=0.
